// File: rtl/game_pkg.sv
// Shared types for the scripted-play sequencer: direction codes, outcome
// codes, sequencer states and the direction-to-pulse decode.
package game_pkg;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_S = 2'd1,
        DIR_E = 2'd2,
        DIR_W = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        RES_NONE  = 3'd0,
        RES_WIN   = 3'd1,
        RES_DEAD  = 3'd2,
        RES_EMPTY = 3'd3,
        RES_LIMIT = 3'd4
    } result_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_GAME,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } seq_state_t;

    // Returns {n,s,e,w} with exactly one bit set.
    function automatic logic [3:0] dir_onehot(input dir_t dir);
        logic [3:0] oh;
        case (dir)
            DIR_N:   oh = 4'b1000;
            DIR_S:   oh = 4'b0100;
            DIR_E:   oh = 4'b0010;
            default: oh = 4'b0001;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/game_move_sequencer_if.sv
// Host command channel: valid/ready handshake carrying one direction code.
interface game_move_sequencer_if;
    import game_pkg::*;

    logic cmd_valid;
    logic cmd_ready;
    dir_t cmd_dir;

    modport master (output cmd_valid, output cmd_dir, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_dir, output cmd_ready);

endinterface

// File: rtl/move_fifo.sv
// Command FIFO. No bypass: head reflects only entries stored at an earlier edge.
// Flush clears the pointers and wins over a push in the same cycle.
module move_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 2
) (
    input  logic         clock,
    input  logic         R,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage write; suppressed when the same cycle flushes.
    always_ff @(posedge clock) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock) begin
        if (R || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/game_move_sequencer.sv
// Scripted-play controller: resets the game, replays buffered directions one
// pulse per move with a fixed gap, and stops on win, death, limit or empty.
//
//   state       | meaning
//   ------------+------------------------------------------------------
//   ST_IDLE     | after reset, waiting for start
//   ST_RST_GAME | one cycle holding game_R high
//   ST_ISSUE    | one cycle driving the head direction, popping it
//   ST_WAIT     | gap countdown, watching win/d every cycle
//   ST_DONE     | outcome latched in result, waiting for start
module game_move_sequencer
    import game_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int GAP       = 2,
    parameter int MAX_MOVES = 15,
    parameter int CNT_W     = 4
) (
    input  logic                 clock,
    input  logic                 R,
    game_move_sequencer_if.slave cmd,
    input  logic                 flush,
    input  logic                 start,
    output logic                 game_R,
    output logic                 n,
    output logic                 s,
    output logic                 e,
    output logic                 w,
    input  logic                 win,
    input  logic                 d,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           result,
    output logic [CNT_W-1:0]     move_count
);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    seq_state_t       state_q, state_d;
    result_t          res_q, res_d;
    logic [GW-1:0]    gap_q;
    logic [CNT_W-1:0] mc_q;
    logic             idle_or_done;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [1:0]       head;
    logic [3:0]       dir_oh;

    assign idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);

    move_fifo #(.DEPTH(DEPTH), .W(2)) u_fifo (
        .clock (clock),
        .R     (R),
        .push  (cmd.cmd_valid),
        .pop   (fifo_pop),
        .flush (flush && idle_or_done),
        .wdata (cmd.cmd_dir),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign cmd.cmd_ready = !fifo_full;
    assign {n, s, e, w}  = dir_oh;
    assign result        = res_q;
    assign move_count    = mc_q;

    // State register.
    always_ff @(posedge clock) begin
        if (R) state_q <= ST_IDLE;
        else   state_q <= state_d;
    end

    // Next state and the outcome it latches.
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RST_GAME;
                    res_d   = RES_NONE;
                end
            end
            ST_RST_GAME: begin
                if (fifo_empty) begin
                    state_d = ST_DONE;
                    res_d   = RES_EMPTY;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (win) begin
                    state_d = ST_DONE;
                    res_d   = RES_WIN;
                end else if (d) begin
                    state_d = ST_DONE;
                    res_d   = RES_DEAD;
                end else if (gap_q == '0) begin
                    if (mc_q == CNT_W'(MAX_MOVES)) begin
                        state_d = ST_DONE;
                        res_d   = RES_LIMIT;
                    end else if (fifo_empty) begin
                        state_d = ST_DONE;
                        res_d   = RES_EMPTY;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outcome, move counter and gap down-counter.
    always_ff @(posedge clock) begin
        if (R) begin
            res_q <= RES_NONE;
            mc_q  <= '0;
            gap_q <= '0;
        end else begin
            res_q <= res_d;
            if (idle_or_done && start)  mc_q <= '0;
            else if (state_q == ST_ISSUE) mc_q <= mc_q + CNT_W'(1);
            if (state_q == ST_ISSUE)
                gap_q <= GW'(GAP - 1);
            else if (state_q == ST_WAIT && gap_q != '0)
                gap_q <= gap_q - GW'(1);
        end
    end

    // Moore outputs; direction pulses are killed while R is high.
    always_comb begin
        dir_oh   = 4'b0000;
        fifo_pop = 1'b0;
        game_R   = R || (state_q == ST_RST_GAME);
        busy     = !idle_or_done;
        done     = (state_q == ST_DONE);
        if (state_q == ST_ISSUE && !R) begin
            dir_oh   = dir_onehot(dir_t'(head));
            fifo_pop = 1'b1;
        end
    end

endmodule

// File: tb/tb_game_move_sequencer.sv
// Bench for game_move_sequencer with a behavioural adventure-game model.
module tb_game_move_sequencer;
    import game_pkg::*;

    localparam int GAP = 2;

    logic clock = 1'b0;
    logic R = 1'b1;
    logic start = 1'b0;
    logic flush = 1'b0;
    logic game_R, n, s, e, w, win, d, busy, done;
    logic [2:0] result;
    logic [3:0] move_count;

    logic lim_start = 1'b0;
    logic lim_flush = 1'b0;
    logic lim_game_R, lim_n, lim_s, lim_e, lim_w, lim_busy, lim_done;
    logic [2:0] lim_result;
    logic [3:0] lim_mc;
    logic tie0 = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_cyc = 0;
    int pulse_cnt = 0;
    int gr_cnt = 0;
    int lim_pulses = 0;
    dir_t exp_q[$];

    game_move_sequencer_if cmd_bus();
    game_move_sequencer_if lim_bus();

    always #5 clock = ~clock;

    game_move_sequencer dut (
        .clock(clock), .R(R), .cmd(cmd_bus.slave), .flush(flush), .start(start),
        .game_R(game_R), .n(n), .s(s), .e(e), .w(w), .win(win), .d(d),
        .busy(busy), .done(done), .result(result), .move_count(move_count)
    );

    game_move_sequencer #(.MAX_MOVES(3)) dut_lim (
        .clock(clock), .R(R), .cmd(lim_bus.slave), .flush(lim_flush), .start(lim_start),
        .game_R(lim_game_R), .n(lim_n), .s(lim_s), .e(lim_e), .w(lim_w), .win(tie0), .d(tie0),
        .busy(lim_busy), .done(lim_done), .result(lim_result), .move_count(lim_mc)
    );

    // Adventure game model: rooms plus a sword flag.
    typedef enum logic [2:0] {RM_CAVE, RM_TUNNEL, RM_RIVER, RM_STASH, RM_DEN} room_t;
    room_t room = RM_CAVE;
    logic  sword = 1'b0;

    always @(posedge clock) begin
        if (game_R) begin
            room  <= RM_CAVE;
            sword <= 1'b0;
        end else begin
            case (room)
                RM_CAVE:   if (e) room <= RM_TUNNEL;
                RM_TUNNEL: if (s) room <= RM_RIVER; else if (w) room <= RM_CAVE;
                RM_RIVER: begin
                    if (w) begin room <= RM_STASH; sword <= 1'b1; end
                    else if (n) room <= RM_TUNNEL;
                    else if (e) room <= RM_DEN;
                end
                RM_STASH:  if (e) room <= RM_RIVER;
                default: ;
            endcase
        end
    end

    assign win = (room == RM_DEN) && sword;
    assign d   = (room == RM_DEN) && !sword;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Pulse monitor: pops the scoreboard on every direction pulse.
    always @(negedge clock) begin
        dir_t exp_dir;
        if (n | s | e | w) begin
            pulse_cnt++;
            chk("pulse_onehot", $countones({n, s, e, w}), 1);
            if (exp_q.size() == 0) begin
                chk("extra_pulse", {28'd0, n, s, e, w}, 0);
            end else begin
                exp_dir = exp_q.pop_front();
                chk("pulse_dir", {28'd0, n, s, e, w}, 32'(4'b1000 >> exp_dir));
            end
            if (pulse_cnt > 1) chk("pulse_gap", cyc - last_cyc, GAP + 1);
            last_cyc = cyc;
        end
        if (game_R) gr_cnt++;
        if (lim_n | lim_s | lim_e | lim_w) lim_pulses++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input dir_t dir);
        chk("push_ready", cmd_bus.cmd_ready, 1);
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_dir   = dir;
        tick();
        cmd_bus.cmd_valid = 1'b0;
        exp_q.push_back(dir);
    endtask

    task automatic run(input string tag, input logic [2:0] exp_res, input int exp_mc,
                       input int exp_lat, input int exp_pulses, input bit poke);
        int lat;
        pulse_cnt = 0;
        gr_cnt    = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        while (!done && lat < 200) begin
            start = poke && (lat == 4);
            flush = poke && (lat == 7);
            tick();
            lat++;
        end
        start = 1'b0;
        flush = 1'b0;
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_moves"}, move_count, exp_mc);
        chk({tag, "_pulses"}, pulse_cnt, exp_pulses);
        chk({tag, "_gameR"}, gr_cnt, 1);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int lat;
        int accepted;
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_dir   = DIR_N;
        lim_bus.cmd_valid = 1'b0;
        lim_bus.cmd_dir   = DIR_N;

        // Reset state.
        repeat (2) tick();
        chk("rst_gameR_high", game_R, 1);
        R = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, RES_NONE);
        chk("rst_moves", move_count, 0);
        chk("rst_ready", cmd_bus.cmd_ready, 1);
        chk("rst_dirs", {n, s, e, w}, 0);
        chk("rst_gameR_low", game_R, 0);

        // Empty FIFO: DONE two cycles after start.
        run("empty", RES_EMPTY, 0, 2, 0, 1'b0);

        // Winning route with ignored start/flush while busy.
        push(DIR_E); push(DIR_S); push(DIR_W); push(DIR_E); push(DIR_E);
        run("win", RES_WIN, 5, 16, 5, 1'b1);
        chk("win_done", done, 1);

        // Dragon without sword, then FIFO must be empty.
        push(DIR_E); push(DIR_S); push(DIR_E);
        run("dead", RES_DEAD, 3, 10, 3, 1'b0);
        repeat (4) tick();
        run("dead_empty", RES_EMPTY, 0, 2, 0, 1'b0);

        // Command exhaustion after two moves.
        push(DIR_E); push(DIR_S);
        run("exhaust", RES_EMPTY, 2, 8, 2, 1'b0);

        // Reset during WAIT of move 2.
        push(DIR_E); push(DIR_S); push(DIR_W);
        pulse_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("mid_pulses", pulse_cnt, 2);
        chk("mid_busy", busy, 1);
        R = 1'b1;
        #1;
        chk("mid_gameR", game_R, 1);
        exp_q.delete();
        tick();
        R = 1'b0;
        #1;
        chk("mid_busy_after", busy, 0);
        chk("mid_done_after", done, 0);
        chk("mid_result_after", result, RES_NONE);
        chk("mid_moves_after", move_count, 0);
        chk("mid_dirs_after", {n, s, e, w}, 0);
        chk("mid_ready_after", cmd_bus.cmd_ready, 1);
        repeat (6) tick();
        run("mid_empty", RES_EMPTY, 0, 2, 0, 1'b0);

        // Flush in DONE discards queued commands.
        push(DIR_E); push(DIR_S);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_q.delete();
        chk("flush_ready", cmd_bus.cmd_ready, 1);
        run("flush", RES_EMPTY, 0, 2, 0, 1'b0);

        // Backpressure and move limit on the MAX_MOVES=3 instance.
        for (int i = 0; i < 8; i++) begin
            chk("lim_push_ready", lim_bus.cmd_ready, 1);
            lim_bus.cmd_valid = 1'b1;
            lim_bus.cmd_dir   = (i % 2 == 0) ? DIR_E : DIR_W;
            tick();
        end
        lim_bus.cmd_valid = 1'b0;
        chk("lim_full", lim_bus.cmd_ready, 0);
        lim_bus.cmd_valid = 1'b1;
        lim_bus.cmd_dir   = DIR_E;
        tick();
        lim_bus.cmd_valid = 1'b0;
        chk("lim_ninth", lim_bus.cmd_ready, 0);
        lim_pulses = 0;
        lim_start = 1'b1;
        tick();
        lim_start = 1'b0;
        lat = 1;
        while (!lim_done && lat < 200) begin
            tick();
            lat++;
        end
        chk("lim_lat", lat, 11);
        chk("lim_result", lim_result, RES_LIMIT);
        chk("lim_moves", lim_mc, 3);
        chk("lim_pulses", lim_pulses, 3);
        chk("lim_busy", lim_busy, 0);
        chk("lim_gameR", lim_game_R, 0);
        accepted = 0;
        lim_bus.cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (lim_bus.cmd_ready) accepted++;
            tick();
        end
        lim_bus.cmd_valid = 1'b0;
        chk("lim_left", accepted, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
